mux_key: RTL and testbench

Parameterised key-to-data lookup multiplexer. It compares a `KEY_LEN`-bit key against `NR_KEY` packed {key, data} pairs and returns the matching data word. The combinational result drives datapath selects, such as the ALU signed/unsigned "less" select; key=0 picks the signed result, key=1 the unsigned one. A registered copy of the result and its hit flag serves pipelined consumers.

---
 rtl/mux_key_if.sv | 24 ++
 rtl/mux_key.sv | 56 +++++
 tb/tb_mux_key.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mux_key_if.sv
// mux_key_if: lookup bus carrying key, table, miss value and the combinational/registered results
interface mux_key_if #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
);
    logic [KEY_LEN-1:0]                     key;
    logic [DATA_LEN-1:0]                    default_out;
    logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut;
    logic [DATA_LEN-1:0]                    out;
    logic                                   hit;
    logic [DATA_LEN-1:0]                    out_q;
    logic                                   hit_q;

    modport master (
        output key, default_out, lut,
        input  out, hit, out_q, hit_q
    );

    modport slave (
        input  key, default_out, lut,
        output out, hit, out_q, hit_q
    );
endinterface

// File: rtl/mux_key.sv
// mux_key: keyed lookup multiplexer, lowest matching entry wins, with registered result copy
module mux_key #(
    parameter int NR_KEY      = 2,
    parameter int KEY_LEN     = 1,
    parameter int DATA_LEN    = 1,
    parameter bit HAS_DEFAULT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_key_if.slave   bus
);
    localparam int W = KEY_LEN + DATA_LEN;

    generate
        if (NR_KEY < 1 || KEY_LEN < 1 || DATA_LEN < 1) begin : g_bad_params
            $error("mux_key: NR_KEY, KEY_LEN and DATA_LEN must all be >= 1");
        end
    endgenerate

    logic [NR_KEY-1:0]   match;
    logic [NR_KEY-1:0]   first;
    logic [DATA_LEN-1:0] sel;
    logic [DATA_LEN-1:0] miss_val;

    // exact compare of every entry key against the lookup key
    always_comb begin
        match = '0;
        for (int i = 0; i < NR_KEY; i++)
            match[i] = bus.lut[i*W+DATA_LEN +: KEY_LEN] == bus.key;
    end

    // isolating the lowest set match bit gives a one-hot winner, so duplicates resolve to entry 0 side
    assign first = match & (~match + NR_KEY'(1));

    // one-hot AND-OR select of the winning entry's data
    always_comb begin
        sel = '0;
        for (int i = 0; i < NR_KEY; i++)
            sel = sel | ({DATA_LEN{first[i]}} & bus.lut[i*W +: DATA_LEN]);
    end

    assign miss_val = HAS_DEFAULT ? bus.default_out : '0;
    assign bus.hit  = |match;
    assign bus.out  = bus.hit ? sel : miss_val;

    // registered copy for pipelined consumers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_q <= '0;
            bus.hit_q <= 1'b0;
        end else begin
            bus.out_q <= bus.out;
            bus.hit_q <= bus.hit;
        end
    end
endmodule

// File: tb/tb_mux_key.sv
// tb_mux_key: directed and random lookups checked through an expectation queue and a negedge monitor
module tb_mux_key;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  key;
    logic [39:0] lut;
    logic [7:0]  dflt;

    mux_key_if #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(1)) ba ();
    mux_key_if #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) bb ();
    mux_key_if #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) bc ();

    mux_key ua (.clk(clk), .rst_n(rst_n), .bus(ba));
    mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(1)) ub (.clk(clk), .rst_n(rst_n), .bus(bb));
    mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(0)) uc (.clk(clk), .rst_n(rst_n), .bus(bc));

    assign bb.key = key;
    assign bb.lut = lut;
    assign bb.default_out = dflt;
    assign bc.key = key;
    assign bc.lut = lut;
    assign bc.default_out = dflt;

    typedef struct {
        int         id;
        logic [7:0] o;
        logic       h;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic a_o, a_h;

    exp_t       e;
    logic [7:0] ao;
    logic       ah;

    always @(negedge clk) begin
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.id)
                0: begin ao = {7'd0, ba.out};   ah = ba.hit;   end
                1: begin ao = {7'd0, ba.out_q}; ah = ba.hit_q; end
                2: begin ao = bb.out;           ah = bb.hit;   end
                default: begin ao = bc.out;     ah = bc.hit;   end
            endcase
            checks++;
            if (ao !== e.o || ah !== e.h) begin
                failures++;
                $display("FAIL %s: got out=%h hit=%b, expected out=%h hit=%b", e.nm, ao, ah, e.o, e.h);
            end
        end
    end

    function automatic exp_t mk(input int id, input logic [7:0] o, input logic h, input string nm);
        exp_t x;
        x.id = id; x.o = o; x.h = h; x.nm = nm;
        return x;
    endfunction

    function automatic logic [8:0] ref_bc(input logic [1:0] k, input logic [39:0] l, input logic [7:0] d, input bit hd);
        for (int i = 0; i < 4; i++)
            if (l[i*10+8 +: 2] == k) return {1'b1, l[i*10 +: 8]};
        return {1'b0, hd ? d : 8'h00};
    endfunction

    task automatic tick();
        logic r, o, h;
        r = rst_n; o = a_o; h = a_h;
        @(posedge clk);
        #1;
        sb.push_back(mk(1, r ? {7'd0, o} : 8'h00, r ? h : 1'b0, "a_reg"));
    endtask

    task automatic expect_a(input logic o, input logic h, input string nm);
        a_o = o; a_h = h;
        sb.push_back(mk(0, {7'd0, o}, h, nm));
    endtask

    task automatic expect_bc(input logic [7:0] ob, input logic hb, input logic [7:0] oc, input logic hc, input string nm);
        sb.push_back(mk(2, ob, hb, {nm, "_hd1"}));
        sb.push_back(mk(3, oc, hc, {nm, "_hd0"}));
    endtask

    logic [7:0] sw_exp [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [8:0] rb, rc;

    initial begin
        rst_n = 1'b0;
        ba.key = 1'b0;
        ba.lut = {1'b0, 1'b1, 1'b1, 1'b0};
        ba.default_out = 1'b0;
        key = 2'd0; lut = '0; dflt = 8'h00;
        a_o = 1'b1; a_h = 1'b1;

        tick(); expect_a(1'b1, 1'b1, "a_key0_in_reset");
        tick(); expect_a(1'b1, 1'b1, "a_key0_in_reset2");
        rst_n = 1'b1;

        tick(); ba.key = 1'b1; expect_a(1'b0, 1'b1, "a_key1");
        tick(); ba.lut = {1'b0, 1'b0, 1'b1, 1'b1}; expect_a(1'b1, 1'b1, "a_toggle_b");
        tick(); ba.key = 1'b0; expect_a(1'b0, 1'b1, "a_key0_toggled");
        tick(); ba.lut = {1'b0, 1'b1, 1'b1, 1'b1}; expect_a(1'b1, 1'b1, "a_toggle_a");
        tick(); ba.key = 1'b1; rst_n = 1'b0; expect_a(1'b1, 1'b1, "a_midreset");
        tick(); ba.key = 1'b0; rst_n = 1'b1; expect_a(1'b1, 1'b1, "a_release");
        tick(); ba.key = 1'b1; ba.lut = {1'b0, 1'b1, 1'b1, 1'b0}; expect_a(1'b0, 1'b1, "a_after_release");

        lut = {2'd3, 8'hA3, 2'd2, 8'hA2, 2'd1, 8'hA1, 2'd0, 8'hA0};
        for (int k = 0; k < 4; k++) begin
            tick(); key = 2'(k); expect_bc(sw_exp[k], 1'b1, sw_exp[k], 1'b1, $sformatf("sweep_k%0d", k));
        end

        tick(); lut = {2'd0, 8'hC3, 2'd2, 8'hC2, 2'd1, 8'hC1, 2'd0, 8'hC0}; key = 2'd3; dflt = 8'h5A;
        expect_bc(8'h5A, 1'b0, 8'h00, 1'b0, "miss_k3");
        tick(); key = 2'd2; expect_bc(8'hC2, 1'b1, 8'hC2, 1'b1, "hit_k2");
        tick(); key = 2'd0; expect_bc(8'hC0, 1'b1, 8'hC0, 1'b1, "dup_k0");
        tick(); key = 2'd3; dflt = 8'hA5; expect_bc(8'hA5, 1'b0, 8'h00, 1'b0, "miss_dflt_change");

        tick(); lut = {2'd2, 8'h44, 2'd3, 8'h33, 2'd1, 8'h11, 2'd1, 8'h22}; key = 2'd1;
        expect_bc(8'h22, 1'b1, 8'h22, 1'b1, "dup_k1");
        tick(); key = 2'd0; expect_bc(8'hA5, 1'b0, 8'h00, 1'b0, "dup_lut_miss");
        tick(); key = 2'd3; expect_bc(8'h33, 1'b1, 8'h33, 1'b1, "dup_lut_k3");
        tick(); lut = {2'd2, 8'h44, 2'd3, 8'h33, 2'd2, 8'h11, 2'd1, 8'h22}; key = 2'd2;
        expect_bc(8'h11, 1'b1, 8'h11, 1'b1, "prio_entry1");

        for (int n = 0; n < 1000; n++) begin
            tick();
            key = 2'($urandom);
            lut = {8'($urandom), 32'($urandom)};
            dflt = 8'($urandom);
            rb = ref_bc(key, lut, dflt, 1'b1);
            rc = ref_bc(key, lut, dflt, 1'b0);
            expect_bc(rb[7:0], rb[8], rc[7:0], rc[8], $sformatf("rnd%0d", n));
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
